// File: rtl/enable_gen_multi.sv
// rtl/enable_gen_multi.sv - multi-channel divided enable/toggle generator with shared pause, step and taps
//
// Ports:
//   clk          system (pixel) clock
//   rst          synchronous reset, active high
//   pause_pulse  debounced pause button level; each release toggles the pause state
//   step         single-step request, honoured only while paused and not mid-press
//   tick         per-channel registered enable pulse (MODE bit 0) or square-wave toggle (MODE bit 1)
//   paused       registered pause state
//   tap_a        channel-0 counter bit TAP_A
//   tap_b        channel-0 counter bit TAP_B
module enable_gen_multi #(
    parameter int                     N_CH         = 3,
    parameter int                     CNT_W        = 23,
    parameter logic [N_CH*CNT_W-1:0]  DIVS         = {23'd6800000, 23'd3400000, 23'd120000},
    parameter logic [N_CH-1:0]        MODE         = 3'b110,
    parameter logic [N_CH-1:0]        PAUSE_EXEMPT = 3'b000,
    parameter int                     TAP_A        = 15,
    parameter int                     TAP_B        = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pause_pulse,
    input  logic            step,
    output logic [N_CH-1:0] tick,
    output logic            paused,
    output logic            tap_a,
    output logic            tap_b
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic            arm;
    logic            paused_q;
    logic [N_CH-1:0] running;
    logic            step_fire;
    logic [CNT_W-1:0] cnt0;

    // Pause state: a press arms, the first low sample after the press toggles.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm      <= 1'b0;
            paused_q <= 1'b0;
        end else if (pause_pulse) begin
            arm <= 1'b1;
        end else if (arm) begin
            paused_q <= ~paused_q;
            arm      <= 1'b0;
        end
    end

    assign paused = paused_q;

    // Registered paused is used, so a toggle only affects counting from the next cycle.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            running[i] = !paused_q || PAUSE_EXEMPT[i];
        end
    end

    // Step only makes sense for a pulse-mode channel 0 that is actually frozen.
    assign step_fire = paused_q && !arm && step && !MODE[0] && !PAUSE_EXEMPT[0];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [CNT_W-1:0] DIV = DIVS[i*CNT_W +: CNT_W];

        logic [CNT_W-1:0] cnt_q;
        logic             tick_q;
        logic             term;

        assign term = (cnt_q >= DIV);

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else if (running[i]) begin
                cnt_q <= term ? '0 : cnt_q + ONE;
                if (MODE[i]) begin
                    tick_q <= tick_q ^ term;
                end else begin
                    tick_q <= term;
                end
            end else if (!MODE[i]) begin
                // Frozen pulse channel: silent except for a step request on channel 0.
                tick_q <= (i == 0) ? step_fire : 1'b0;
            end
        end

        assign tick[i] = tick_q;

        if (i == 0) begin : g_tap
            assign cnt0 = cnt_q;
        end
    end

    assign tap_a = cnt0[TAP_A];
    assign tap_b = cnt0[TAP_B];

endmodule

// File: tb/tb_enable_gen_multi.sv
// tb/tb_enable_gen_multi.sv - self-checking bench for enable_gen_multi
module tb_enable_gen_multi;

    localparam int CW = 8;
    localparam logic [3*CW-1:0] DV_AB = {8'd7, 8'd5, 8'd3};
    localparam logic [3*CW-1:0] DV_C  = {8'd7, 8'd5, 8'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pause_pulse = 1'b0;
    logic step = 1'b0;

    logic [2:0] tick_a, tick_b, tick_c;
    logic       paused_a, paused_b, paused_c;
    logic       tap_a_a, tap_a_b, tap_a_c;
    logic       tap_b_a, tap_b_b, tap_b_c;

    always #5 clk = ~clk;

    enable_gen_multi #(.N_CH(3), .CNT_W(CW), .DIVS(DV_AB), .MODE(3'b110),
                       .PAUSE_EXEMPT(3'b000), .TAP_A(1), .TAP_B(0)) dut_a (
        .clk(clk), .rst(rst), .pause_pulse(pause_pulse), .step(step),
        .tick(tick_a), .paused(paused_a), .tap_a(tap_a_a), .tap_b(tap_b_a));

    enable_gen_multi #(.N_CH(3), .CNT_W(CW), .DIVS(DV_AB), .MODE(3'b110),
                       .PAUSE_EXEMPT(3'b010), .TAP_A(1), .TAP_B(0)) dut_b (
        .clk(clk), .rst(rst), .pause_pulse(pause_pulse), .step(step),
        .tick(tick_b), .paused(paused_b), .tap_a(tap_a_b), .tap_b(tap_b_b));

    enable_gen_multi #(.N_CH(3), .CNT_W(CW), .DIVS(DV_C), .MODE(3'b110),
                       .PAUSE_EXEMPT(3'b000), .TAP_A(1), .TAP_B(0)) dut_c (
        .clk(clk), .rst(rst), .pause_pulse(pause_pulse), .step(step),
        .tick(tick_c), .paused(paused_c), .tap_a(tap_a_c), .tap_b(tap_b_c));

    logic [2:0] tk [3];
    logic       pz [3];
    logic       ta [3];
    logic       tb [3];
    assign tk[0] = tick_a;   assign tk[1] = tick_b;   assign tk[2] = tick_c;
    assign pz[0] = paused_a; assign pz[1] = paused_b; assign pz[2] = paused_c;
    assign ta[0] = tap_a_a;  assign ta[1] = tap_a_b;  assign ta[2] = tap_a_c;
    assign tb[0] = tap_b_a;  assign tb[1] = tap_b_b;  assign tb[2] = tap_b_c;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is described by how many running edges it has
    // seen since reset; counter value, pulse and toggle level follow arithmetically.
    int         dv [3][3] = '{'{3, 5, 7}, '{3, 5, 7}, '{0, 5, 7}};
    logic [2:0] ex [3]    = '{3'b000, 3'b010, 3'b000};
    logic [2:0] md        = 3'b110;
    int         m_n [3][3];
    bit         m_paused [3];
    bit         m_arm [3];
    logic [2:0] m_tick [3];

    always @(posedge clk) begin : model
        bit sf;
        bit run;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                for (int i = 0; i < 3; i++) m_n[k][i] = 0;
                m_tick[k]   = 3'b000;
                m_paused[k] = 1'b0;
                m_arm[k]    = 1'b0;
            end else begin
                sf = m_paused[k] && !m_arm[k] && step && !md[0] && !ex[k][0];
                for (int i = 0; i < 3; i++) begin
                    run = !m_paused[k] || ex[k][i];
                    if (run) begin
                        m_n[k][i] = m_n[k][i] + 1;
                        if (md[i])
                            m_tick[k][i] = ((m_n[k][i] / (dv[k][i] + 1)) % 2) == 1;
                        else
                            m_tick[k][i] = (m_n[k][i] % (dv[k][i] + 1)) == 0;
                    end else if (!md[i]) begin
                        m_tick[k][i] = (i == 0) ? sf : 1'b0;
                    end
                end
                if (pause_pulse) begin
                    m_arm[k] = 1'b1;
                end else if (m_arm[k]) begin
                    m_paused[k] = !m_paused[k];
                    m_arm[k]    = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : model_check
        int c0;
        for (int k = 0; k < 3; k++) begin
            c0 = m_n[k][0] % (dv[k][0] + 1);
            chk($sformatf("model_tick_dut%0d", k), 32'(tk[k]), 32'(m_tick[k]));
            chk($sformatf("model_paused_dut%0d", k), 32'(pz[k]), 32'(m_paused[k]));
            chk($sformatf("model_tap_a_dut%0d", k), 32'(ta[k]), 32'((c0 >> 1) & 1));
            chk($sformatf("model_tap_b_dut%0d", k), 32'(tb[k]), 32'(c0 & 1));
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       pp;
        logic       st;
        logic [2:0] tick;
        logic       paused;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int found;
        int first;

        // Reset held two edges, then edges 1..12 after release.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 3'b001, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 3'b010, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'b111, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 3'b110, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 3'b110, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 3'b110, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 3'b101, 1'b0};

        for (int r = 0; r < 14; r++) begin
            rst         = tbl[r].rst;
            pause_pulse = tbl[r].pp;
            step        = tbl[r].st;
            step_clk();
            chk($sformatf("vec%0d_tick", r), 32'(tick_a), 32'(tbl[r].tick));
            chk($sformatf("vec%0d_paused", r), 32'(paused_a), 32'(tbl[r].paused));
        end

        // Long press: one toggle, on the first edge that samples the release.
        pause_pulse = 1'b1;
        repeat (10) step_clk();
        chk("press_held_not_paused", 32'(paused_a), 32'd0);
        pause_pulse = 1'b0;
        step_clk();
        chk("press_release_paused", 32'(paused_a), 32'd1);
        step_clk();
        for (int c = 0; c < 8; c++) begin
            step_clk();
            chk($sformatf("paused_tick0_off_%0d", c), 32'(tick_a[0]), 32'd0);
            chk($sformatf("paused_div0_tick0_off_%0d", c), 32'(tick_c[0]), 32'd0);
        end

        // Single step, then held step.
        step = 1'b1;
        step_clk();
        chk("step_pulse", 32'(tick_a[0]), 32'd1);
        step = 1'b0;
        step_clk();
        chk("step_pulse_end", 32'(tick_a[0]), 32'd0);
        step = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step_clk();
            chk($sformatf("step_held_%0d", c), 32'(tick_a[0]), 32'd1);
        end
        step = 1'b0;
        step_clk();

        // Step ignored while a press is in progress; release then unpauses.
        pause_pulse = 1'b1;
        step_clk();
        step = 1'b1;
        step_clk();
        chk("step_while_armed", 32'(tick_a[0]), 32'd0);
        step = 1'b0;
        pause_pulse = 1'b0;
        step_clk();
        chk("second_release_unpaused", 32'(paused_a), 32'd0);

        // Step while running has no extra effect (the model checks it).
        step = 1'b1;
        step_clk();
        step = 1'b0;
        step_clk();

        // Reset with cnt0 == 2 and the pause armed.
        pause_pulse = 1'b1;
        found = 0;
        for (int w = 0; w < 20 && found == 0; w++) begin
            if ((m_n[0][0] % 4) == 2 && m_arm[0]) found = 1;
            else step_clk();
        end
        chk("found_cnt2_armed", 32'(found), 32'd1);
        rst = 1'b1;
        step_clk();
        chk("midrst_tick", 32'(tick_a), 32'd0);
        chk("midrst_paused", 32'(paused_a), 32'd0);
        rst = 1'b0;
        pause_pulse = 1'b0;
        first = 0;
        for (int e = 1; e <= 10; e++) begin
            step_clk();
            if (tick_a[0] && first == 0) first = e;
            chk($sformatf("div0_tick0_high_%0d", e), 32'(tick_c[0]), 32'd1);
        end
        chk("midrst_first_pulse_edge", 32'(first), 32'd4);
        chk("midrst_no_pause_toggle", 32'(paused_a), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) pause_pulse = ~pause_pulse;
            step = ($urandom_range(0, 3) == 0);
            step_clk();
        end
        rst = 1'b0;
        pause_pulse = 1'b0;
        step = 1'b0;
        step_clk();
        step_clk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
